fir_ctrl: RTL and testbench
===========================

# fir_ctrl

Sequencer for the FIR datapath. Accepts one input sample at a time and writes it into a 128-entry circular sample RAM. It then walks the coefficient RAM read port and the sample RAM read port in lockstep, driving an internal multiply-accumulate pipeline. It emits one rounded, saturated output per accepted sample. It sits between the sample source and the two dual-port RAMs (coefficient RAM on read-only port 2, sample RAM on write port 1 and read port 2).

## Interface
Parameters:
- NTAPS, 64: number of taps evaluated per sample; legal range 1..128.
- DW, 18: sample/coefficient/output width.
- AW, 7: RAM address width (128 words).
- ACCW, 43: accumulator width (2·DW+AW).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- din_valid  in  1  input sample strobe.
- din  in  DW  signed sample.
- din_ready  out  1  high only in IDLE.
- coef_addr  out  AW  coefficient RAM read address.
- coef_data  in  DW  coefficient RAM data, signed Q1.17, 1-cycle read latency.
- smp_we  out  1  sample RAM write enable.
- smp_waddr  out  AW  sample RAM write address.
- smp_wdata  out  DW  sample RAM write data.
- smp_raddr  out  AW  sample RAM read address.
- smp_rdata  in  DW  sample RAM read data, 1-cycle read latency.
- dout  out  DW  filtered sample, signed.
- dout_valid  out  1  one-cycle strobe.

## Operation
- States: CLEAR, IDLE, WRITE, MAC, DRAIN, OUT.
- CLEAR (entered on reset)
  - Writes 0 to sample addresses 0..127, one per cycle: smp_we=1, smp_waddr=clear counter.
  - Lasts 128 cycles, then goes to IDLE.
  - din_ready=0 throughout.
- IDLE
  - din_ready=1.
  - On din_valid, registers din and goes to WRITE.
- WRITE (1 cycle)
  - smp_we=1, smp_waddr=wptr, smp_wdata=registered sample.
  - Clears the accumulator.
- MAC (NTAPS cycles, k=0..NTAPS-1)
  - coef_addr=k.
  - smp_raddr=(wptr−k) mod 128.
  - AW-bit subtraction, natural wrap.
- DRAIN (3 cycles): flushes the read-data, product and accumulate stages.
- OUT (1 cycle)
  - dout_valid=1 with the registered result.
  - wptr ← wptr+1, wrapping 127→0.
  - din_ready=1 and the block is in IDLE from this cycle, so a new sample may be accepted in the same cycle.
- MAC pipeline
  - Stage 1: product = coef_data × smp_rdata, signed 2·DW bits, registered.
  - Stage 2: acc += sign-extended product.
  - A valid bit tracks each stage; only valid products accumulate.
- Output arithmetic
  - r = acc + 2^16.
  - dout = r[ACCW-1:17], saturated to DW-bit signed: +131071 max, −131072 min.
  - This rounds half up.
- din_valid while din_ready=0 is ignored; the sample is not captured.
- No writes or reads of coefficient RAM other than addresses 0..NTAPS-1.

## Timing
- Reset values: all outputs 0, except smp_we=1 from the first clock edge after reset deasserts (CLEAR). wptr=0, acc=0, clear counter=0.
- Reset mid-operation (any state): outputs go to 0 immediately. The pending result is discarded and no dout_valid is issued. CLEAR reruns.
- Acceptance at cycle 0 gives:
  - WRITE at cycle 1.
  - MAC at cycles 2..NTAPS+1.
  - DRAIN at NTAPS+2..NTAPS+4.
  - dout_valid at cycle NTAPS+5.
- Throughput: one sample per NTAPS+5 cycles.
- The write in cycle 1 is visible to the read issued in cycle 2 (read-after-write on separate ports, registered read).
- dout holds its value until the next OUT.

## Structure
- Package fir_pkg holds:
  - DW, AW, ACCW defaults.
  - State enum.
  - Rounding constant (1<<16).
  - Saturation limits.
- Sub-module fir_mac: 2-stage multiply/accumulate with clear, valid-in, and the result output.
- The FSM, address generation and round/saturate logic live in fir_ctrl.

## Test plan
- Reset release → din_ready=0 for 128 cycles; smp_we=1 with smp_waddr 0..127 and smp_wdata=0; then din_ready=1.
- Impulse response, NTAPS=4, coefs 0x10000, 0x08000, 0x04000, 0x02000; din = 1000, 0, 0, 0 → dout = 500, 250, 125, 63.
- Saturation, NTAPS=4, all coefs 0x1FFFF:
  - Four samples of 131071 → fourth dout = 131071.
  - Four samples of −131072 → fourth dout = −131072.
- Back-to-back, din_valid held high, NTAPS=8:
  - Acceptances exactly 13 cycles apart.
  - Each dout_valid 13 cycles after its acceptance.
  - No sample lost or duplicated.
- Wrap-around, NTAPS=4, 130 samples → sample 129 is written at address 1 (wptr wrapped 127→0 at sample 128); its MAC reads addresses 1, 0, 127, 126.
- Reset asserted in mid-MAC → outputs 0 immediately, no dout_valid for that sample, and CLEAR sequence repeats.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared types and constants for the FIR sequencer.
//   FIR_DW / FIR_AW / FIR_ACCW : default sample, address and accumulator widths
//   state_t                    : sequencer states
//   ROUND_CONST, SAT_MAX/MIN   : output rounding offset and saturation limits (Q1.17)
package fir_pkg;

   localparam int FIR_DW    = 18;
   localparam int FIR_AW    = 7;
   localparam int FIR_ACCW  = 2 * FIR_DW + FIR_AW;

   // Coefficients are Q1.17, so the accumulator carries 17 fractional bits.
   localparam int FRAC_BITS = FIR_DW - 1;

   // Half an output LSB: adding it before the shift rounds half up.
   localparam longint ROUND_CONST = longint'(1) <<< (FRAC_BITS - 1);
   localparam longint SAT_MAX     = (longint'(1) <<< (FIR_DW - 1)) - 1;
   localparam longint SAT_MIN     = -(longint'(1) <<< (FIR_DW - 1));

   // Read-data, product and accumulate stages to flush after the last tap.
   localparam int DRAIN_CYCLES = 3;

   typedef enum logic [2:0] {
      S_CLEAR,
      S_IDLE,
      S_WRITE,
      S_MAC,
      S_DRAIN,
      S_OUT
   } state_t;

endpackage

// File: rtl/fir_ctrl_if.sv
// fir_ctrl_if: sample stream and RAM-port bundle of the FIR sequencer.
//   din_valid/din/din_ready   : input sample handshake
//   coef_addr/coef_data       : coefficient RAM read port (1-cycle latency)
//   smp_we/smp_waddr/smp_wdata: sample RAM write port
//   smp_raddr/smp_rdata       : sample RAM read port (1-cycle latency)
//   dout/dout_valid           : filtered output and its one-cycle strobe
// modport master is the sequencer side, modport slave the environment side.
interface fir_ctrl_if
   import fir_pkg::*;
#(
   parameter int DW = FIR_DW,
   parameter int AW = FIR_AW
);

   logic                 din_valid;
   logic signed [DW-1:0] din;
   logic                 din_ready;
   logic [AW-1:0]        coef_addr;
   logic signed [DW-1:0] coef_data;
   logic                 smp_we;
   logic [AW-1:0]        smp_waddr;
   logic signed [DW-1:0] smp_wdata;
   logic [AW-1:0]        smp_raddr;
   logic signed [DW-1:0] smp_rdata;
   logic signed [DW-1:0] dout;
   logic                 dout_valid;

   modport master (
      input  din_valid, din, coef_data, smp_rdata,
      output din_ready, coef_addr, smp_we, smp_waddr, smp_wdata, smp_raddr,
             dout, dout_valid
   );

   modport slave (
      output din_valid, din, coef_data, smp_rdata,
      input  din_ready, coef_addr, smp_we, smp_waddr, smp_wdata, smp_raddr,
             dout, dout_valid
   );

endinterface

// File: rtl/fir_mac.sv
// fir_mac: two-stage multiply/accumulate.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   clear        : zero the accumulator (and drop any product in flight)
//   in_valid     : coef/smp carry a valid tap this cycle
//   coef, smp    : signed operands
//   acc          : running sum of valid products
module fir_mac
   import fir_pkg::*;
#(
   parameter int DW   = FIR_DW,
   parameter int ACCW = FIR_ACCW
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   in_valid,
   input  logic signed [DW-1:0]   coef,
   input  logic signed [DW-1:0]   smp,
   output logic signed [ACCW-1:0] acc
);

   logic signed [2*DW-1:0] prod;
   logic                   prod_valid;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prod       <= '0;
         prod_valid <= 1'b0;
         acc        <= '0;
      end else begin
         // NOTE: non-blocking assignments make every stage sample its pre-edge inputs.
         prod       <= (2*DW)'(coef) * (2*DW)'(smp);
         prod_valid <= in_valid & ~clear;
         if (clear)
            acc <= '0;
         else if (prod_valid)
            acc <= acc + ACCW'(prod);
      end
   end

endmodule

// File: rtl/fir_ctrl.sv
// fir_ctrl: FIR sequencer.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus          : fir_ctrl_if.master (sample handshake, coefficient and
//                  sample RAM ports, filtered output)
// After reset the sample RAM is zeroed, then each accepted sample is written
// at wptr and NTAPS taps are walked newest-to-oldest through fir_mac. The
// accumulator is rounded half up and saturated to DW bits for dout.
module fir_ctrl
   import fir_pkg::*;
#(
   parameter int NTAPS = 64,
   parameter int DW    = FIR_DW,
   parameter int AW    = FIR_AW,
   parameter int ACCW  = FIR_ACCW
) (
   input  logic       clock,
   input  logic       reset,
   fir_ctrl_if.master bus
);

   localparam int QW = ACCW - FRAC_BITS;
   localparam logic signed [QW-1:0] Q_MAX = QW'(SAT_MAX);
   localparam logic signed [QW-1:0] Q_MIN = QW'(SAT_MIN);

   // cnt is one bit wider than an address so the clear walk can count to 2**AW.
   localparam logic [AW:0] CLEAR_LAST = (AW+1)'(2**AW);
   localparam logic [AW:0] MAC_LAST   = (AW+1)'(NTAPS - 1);
   localparam logic [AW:0] DRAIN_LAST = (AW+1)'(DRAIN_CYCLES - 1);

   state_t                 state;
   logic [AW:0]            cnt;
   logic [AW-1:0]          wptr;
   logic                   mac_clear;
   logic                   rd_valid;
   logic signed [ACCW-1:0] acc;
   logic signed [QW-1:0]   q;
   logic signed [DW-1:0]   sat;

   fir_mac #(.DW(DW), .ACCW(ACCW)) u_mac (
      .clock    (clock),
      .reset    (reset),
      .clear    (mac_clear),
      .in_valid (rd_valid),
      .coef     (bus.coef_data),
      .smp      (bus.smp_rdata),
      .acc      (acc)
   );

   assign q = QW'((acc + ACCW'(ROUND_CONST)) >>> FRAC_BITS);

   always_comb begin
      // NOTE: sat gets a value before any branch, so no latch can be inferred.
      sat = q[DW-1:0];
      if (q > Q_MAX)
         sat = DW'(SAT_MAX);
      else if (q < Q_MIN)
         sat = DW'(SAT_MIN);
   end

   // Outputs are registered together with the state they belong to, so each
   // branch sets the values the next state presents.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= S_CLEAR;
         cnt            <= '0;
         wptr           <= '0;
         mac_clear      <= 1'b0;
         rd_valid       <= 1'b0;
         bus.din_ready  <= 1'b0;
         bus.coef_addr  <= '0;
         bus.smp_we     <= 1'b0;
         bus.smp_waddr  <= '0;
         bus.smp_wdata  <= '0;
         bus.smp_raddr  <= '0;
         bus.dout       <= '0;
         bus.dout_valid <= 1'b0;
      end else begin
         // RAM data returns one cycle after a MAC-state address.
         rd_valid       <= (state == S_MAC);
         mac_clear      <= 1'b0;
         bus.dout_valid <= 1'b0;
         case (state)
            S_CLEAR: begin
               if (cnt == CLEAR_LAST) begin
                  state         <= S_IDLE;
                  cnt           <= '0;
                  bus.smp_we    <= 1'b0;
                  bus.din_ready <= 1'b1;
               end else begin
                  bus.smp_we    <= 1'b1;
                  bus.smp_waddr <= cnt[AW-1:0];
                  bus.smp_wdata <= '0;
                  cnt           <= cnt + 1'b1;
               end
            end
            // OUT already behaves as IDLE: a sample may be taken the same cycle.
            S_IDLE, S_OUT: begin
               if (bus.din_valid) begin
                  state         <= S_WRITE;
                  bus.din_ready <= 1'b0;
                  bus.smp_we    <= 1'b1;
                  bus.smp_waddr <= wptr;
                  bus.smp_wdata <= bus.din;
                  mac_clear     <= 1'b1;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_WRITE: begin
               state         <= S_MAC;
               bus.smp_we    <= 1'b0;
               cnt           <= '0;
               bus.coef_addr <= '0;
               bus.smp_raddr <= wptr;
            end
            S_MAC: begin
               if (cnt == MAC_LAST) begin
                  state <= S_DRAIN;
                  cnt   <= '0;
               end else begin
                  cnt           <= cnt + 1'b1;
                  bus.coef_addr <= cnt[AW-1:0] + AW'(1);
                  bus.smp_raddr <= wptr - cnt[AW-1:0] - AW'(1);
               end
            end
            S_DRAIN: begin
               if (cnt == DRAIN_LAST) begin
                  state          <= S_OUT;
                  cnt            <= '0;
                  bus.dout       <= sat;
                  bus.dout_valid <= 1'b1;
                  bus.din_ready  <= 1'b1;
                  wptr           <= wptr + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= S_CLEAR;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: directed bench for fir_ctrl. dut4 runs NTAPS=4, dut8 runs
// NTAPS=8; each has behavioural coefficient and sample RAMs with 1-cycle reads.
`timescale 1ns/1ps
module tb_fir_ctrl;

   localparam int DW = 18;
   localparam int AW = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst4;
   logic rst8;

   fir_ctrl_if #(.DW(DW), .AW(AW)) b4 ();
   fir_ctrl_if #(.DW(DW), .AW(AW)) b8 ();

   fir_ctrl #(.NTAPS(4), .DW(DW), .AW(AW), .ACCW(43)) dut4 (
      .clock (clk),
      .reset (rst4),
      .bus   (b4)
   );

   fir_ctrl #(.NTAPS(8), .DW(DW), .AW(AW), .ACCW(43)) dut8 (
      .clock (clk),
      .reset (rst8),
      .bus   (b8)
   );

   logic signed [DW-1:0] coef4 [128];
   logic signed [DW-1:0] smp4  [128];
   logic signed [DW-1:0] coef8 [128];
   logic signed [DW-1:0] smp8  [128];

   always @(posedge clk) begin
      if (b4.smp_we) smp4[b4.smp_waddr] <= b4.smp_wdata;
      b4.smp_rdata <= smp4[b4.smp_raddr];
      b4.coef_data <= coef4[b4.coef_addr];
   end

   always @(posedge clk) begin
      if (b8.smp_we) smp8[b8.smp_waddr] <= b8.smp_wdata;
      b8.smp_rdata <= smp8[b8.smp_raddr];
      b8.coef_data <= coef8[b8.coef_addr];
   end

   int n_vec = 0;
   int n_err = 0;

   // Values seen on dut4 during the last send4 call.
   logic                 cap_we;
   logic [AW-1:0]        cap_waddr;
   logic signed [DW-1:0] cap_wdata;
   logic [AW-1:0]        cap_raddr [4];
   logic [AW-1:0]        cap_caddr [4];

   // Offer one sample to dut4 (call at a negedge). lat is the cycle after
   // acceptance where dout_valid first rose, or -1 if it never did.
   task automatic send4(input logic signed [DW-1:0] x,
                        output logic signed [DW-1:0] y, output int lat);
      int guard;
      guard = 0;
      y     = '0;
      lat   = -1;
      while (b4.din_ready !== 1'b1 && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (guard < 300) begin
         b4.din_valid = 1'b1;
         b4.din       = x;
         for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
               b4.din_valid = 1'b0;
               cap_we    = b4.smp_we;
               cap_waddr = b4.smp_waddr;
               cap_wdata = b4.smp_wdata;
            end
            if (k >= 2 && k <= 5) begin
               cap_raddr[k-2] = b4.smp_raddr;
               cap_caddr[k-2] = b4.coef_addr;
            end
            if (b4.dout_valid === 1'b1 && lat < 0) begin
               lat = k;
               y   = b4.dout;
            end
         end
      end
   endtask

   task automatic test_reset;
      rst4 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if (b4.din_ready !== 1'b0 || b4.smp_we !== 1'b0 || b4.dout_valid !== 1'b0 ||
          b4.dout !== '0 || b4.smp_waddr !== '0 || b4.smp_wdata !== '0 ||
          b4.smp_raddr !== '0 || b4.coef_addr !== '0) begin
         n_err++;
         $display("FAIL reset_values: ready=%b we=%b dv=%b dout=%0d waddr=%0d wdata=%0d raddr=%0d caddr=%0d, need all 0",
                  b4.din_ready, b4.smp_we, b4.dout_valid, b4.dout, b4.smp_waddr,
                  b4.smp_wdata, b4.smp_raddr, b4.coef_addr);
      end
      rst4 = 1'b0;
      for (int i = 1; i <= 128; i++) begin
         @(negedge clk);
         n_vec++;
         if (b4.din_ready !== 1'b0 || b4.smp_we !== 1'b1 || b4.dout_valid !== 1'b0 ||
             b4.smp_waddr !== AW'(i - 1) || b4.smp_wdata !== '0) begin
            n_err++;
            $display("FAIL clear[%0d]: ready=%b we=%b dv=%b waddr=%0d wdata=%0d, need ready=0 we=1 dv=0 waddr=%0d wdata=0",
                     i, b4.din_ready, b4.smp_we, b4.dout_valid, b4.smp_waddr, b4.smp_wdata, i - 1);
         end
      end
      @(negedge clk);
      n_vec++;
      if (b4.din_ready !== 1'b1 || b4.smp_we !== 1'b0) begin
         n_err++;
         $display("FAIL clear_done: ready=%b we=%b, need ready=1 we=0", b4.din_ready, b4.smp_we);
      end
   endtask

   task automatic test_impulse;
      logic signed [DW-1:0] xin  [4];
      logic signed [DW-1:0] want [4];
      logic signed [DW-1:0] y;
      int lat;
      xin  = '{18'sd1000, 18'sd0, 18'sd0, 18'sd0};
      want = '{18'sd500, 18'sd250, 18'sd125, 18'sd63};
      coef4[0] = 18'sh10000;
      coef4[1] = 18'sh08000;
      coef4[2] = 18'sh04000;
      coef4[3] = 18'sh02000;
      for (int i = 0; i < 4; i++) begin
         send4(xin[i], y, lat);
         n_vec++;
         if (cap_we !== 1'b1 || cap_waddr !== AW'(i) || cap_wdata !== xin[i]) begin
            n_err++;
            $display("FAIL impulse_write[%0d]: we=%b waddr=%0d wdata=%0d, need we=1 waddr=%0d wdata=%0d",
                     i, cap_we, cap_waddr, cap_wdata, i, xin[i]);
         end
         n_vec++;
         if (lat !== 9) begin
            n_err++;
            $display("FAIL impulse_latency[%0d]: got %0d cycles, need 9", i, lat);
         end
         n_vec++;
         if (y !== want[i]) begin
            n_err++;
            $display("FAIL impulse_dout[%0d]: got %0d, need %0d", i, y, want[i]);
         end
      end
   endtask

   task automatic test_saturation;
      logic signed [DW-1:0] y;
      logic signed [DW-1:0] pmax;
      logic signed [DW-1:0] nmin;
      int lat;
      pmax = 18'sd131071;
      nmin = -18'sd131072;
      for (int i = 0; i < 4; i++) coef4[i] = 18'sh1FFFF;
      for (int i = 0; i < 4; i++) send4(pmax, y, lat);
      n_vec++;
      if (lat !== 9 || y !== pmax) begin
         n_err++;
         $display("FAIL sat_pos: got dout=%0d lat=%0d, need dout=131071 lat=9", y, lat);
      end
      for (int i = 0; i < 4; i++) send4(nmin, y, lat);
      n_vec++;
      if (lat !== 9 || y !== nmin) begin
         n_err++;
         $display("FAIL sat_neg: got dout=%0d lat=%0d, need dout=-131072 lat=9", y, lat);
      end
   endtask

   task automatic test_wrap;
      logic signed [DW-1:0] y;
      logic [AW-1:0] want_r [4];
      int lat;
      int bad_lat;
      want_r = '{7'd1, 7'd0, 7'd127, 7'd126};
      bad_lat = 0;
      coef4[0] = 18'sh10000;
      coef4[1] = 18'sh08000;
      coef4[2] = 18'sh04000;
      coef4[3] = 18'sh02000;
      rst4 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst4 = 1'b0;
      for (int i = 0; i < 130; i++) begin
         send4(DW'(i), y, lat);
         if (lat != 9) bad_lat++;
         if (i == 128) begin
            n_vec++;
            if (cap_waddr !== 7'd0) begin
               n_err++;
               $display("FAIL wrap_waddr128: got %0d, need 0", cap_waddr);
            end
         end
      end
      n_vec++;
      if (bad_lat != 0) begin
         n_err++;
         $display("FAIL wrap_latency: %0d samples off 9 cycles, need 0", bad_lat);
      end
      n_vec++;
      if (cap_we !== 1'b1 || cap_waddr !== 7'd1 || cap_wdata !== 18'sd129) begin
         n_err++;
         $display("FAIL wrap_write129: we=%b waddr=%0d wdata=%0d, need we=1 waddr=1 wdata=129",
                  cap_we, cap_waddr, cap_wdata);
      end
      for (int j = 0; j < 4; j++) begin
         n_vec++;
         if (cap_raddr[j] !== want_r[j] || cap_caddr[j] !== AW'(j)) begin
            n_err++;
            $display("FAIL wrap_read[%0d]: raddr=%0d caddr=%0d, need raddr=%0d caddr=%0d",
                     j, cap_raddr[j], cap_caddr[j], want_r[j], j);
         end
      end
      // 0.5*129 + 0.25*128 + 0.125*127 + 0.0625*126 = 120.25, rounds to 120
      n_vec++;
      if (y !== 18'sd120) begin
         n_err++;
         $display("FAIL wrap_dout129: got %0d, need 120", y);
      end
   endtask

   task automatic test_back_to_back;
      int acc_cyc [6];
      int dv_cyc  [6];
      logic signed [DW-1:0] dv_val [6];
      logic signed [DW-1:0] xin [6];
      int na, nd, cyc;
      for (int i = 0; i < 6; i++) xin[i] = DW'(400 * (i + 1));
      coef8[0] = 18'sh10000;
      coef8[1] = 18'sh08000;
      na = 0;
      nd = 0;
      cyc = 0;
      @(negedge clk);
      rst8 = 1'b0;
      while (nd < 6 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (b8.dout_valid === 1'b1) begin
            dv_cyc[nd] = cyc;
            dv_val[nd] = b8.dout;
            nd++;
         end
         if (na < 6) begin
            b8.din_valid = 1'b1;
            b8.din       = xin[na];
         end else begin
            b8.din_valid = 1'b0;
         end
         if (b8.din_ready === 1'b1 && b8.din_valid === 1'b1) begin
            acc_cyc[na] = cyc;
            na++;
         end
      end
      b8.din_valid = 1'b0;
      n_vec++;
      if (na != 6 || nd != 6) begin
         n_err++;
         $display("FAIL b2b_count: accepted=%0d outputs=%0d, need 6 and 6", na, nd);
      end
      for (int i = 1; i < na; i++) begin
         n_vec++;
         if (acc_cyc[i] - acc_cyc[i-1] != 13) begin
            n_err++;
            $display("FAIL b2b_spacing[%0d]: got %0d cycles, need 13", i, acc_cyc[i] - acc_cyc[i-1]);
         end
      end
      for (int i = 0; i < nd && i < na; i++) begin
         n_vec++;
         if (dv_cyc[i] - acc_cyc[i] != 13) begin
            n_err++;
            $display("FAIL b2b_latency[%0d]: got %0d cycles, need 13", i, dv_cyc[i] - acc_cyc[i]);
         end
         // dout[n] = (2*x[n] + x[n-1]) / 4 with x[n] = 400*(n+1)
         n_vec++;
         if (dv_val[i] !== DW'(300 * i + 200)) begin
            n_err++;
            $display("FAIL b2b_dout[%0d]: got %0d, need %0d", i, dv_val[i], 300 * i + 200);
         end
      end
   endtask

   task automatic test_reset_mid_mac;
      int guard;
      guard = 0;
      @(negedge clk);
      while (b4.din_ready !== 1'b1 && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      b4.din_valid = 1'b1;
      b4.din       = 18'sd5000;
      @(negedge clk);
      b4.din_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2;
      rst4 = 1'b1;
      #1;
      n_vec++;
      if (b4.din_ready !== 1'b0 || b4.smp_we !== 1'b0 || b4.dout_valid !== 1'b0 ||
          b4.dout !== '0 || b4.smp_waddr !== '0 || b4.smp_wdata !== '0 ||
          b4.smp_raddr !== '0 || b4.coef_addr !== '0) begin
         n_err++;
         $display("FAIL midmac_reset: ready=%b we=%b dv=%b dout=%0d waddr=%0d wdata=%0d raddr=%0d caddr=%0d, need all 0",
                  b4.din_ready, b4.smp_we, b4.dout_valid, b4.dout, b4.smp_waddr,
                  b4.smp_wdata, b4.smp_raddr, b4.coef_addr);
      end
      // The CLEAR walk reruns and must show no dout_valid for the dropped sample.
      test_reset();
   endtask

   initial begin
      for (int i = 0; i < 128; i++) begin
         coef4[i] = '0;
         coef8[i] = '0;
      end
      rst4 = 1'b1;
      rst8 = 1'b1;
      b4.din_valid = 1'b0;
      b4.din       = '0;
      b8.din_valid = 1'b0;
      b8.din       = '0;
      test_reset();
      test_impulse();
      test_saturation();
      test_wrap();
      test_back_to_back();
      test_reset_mid_mac();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
